// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants and hazard FSM state encoding.
package pipe_pkg;
    typedef enum logic [1:0] {RUN, FLUSH2, MEM_WAIT} hz_state_t;
    localparam logic [31:0] NOP = 32'h0;
    localparam int ZERO_REG_DEF = 31;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else if (en && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and memory-freeze control for the pipeline front end.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles
);
    hz_state_t state, next;
    logic      flag, flag_n, lu;

    assign lu = ex_memread && ex_rd != 5'(ZERO_REG) &&
                (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            flag  <= 1'b0;
        end else begin
            state <= next;
            flag  <= flag_n;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        next        = RUN;
        flag_n      = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            next    = MEM_WAIT;
            flag_n  = flag || state == FLUSH2;
        end else if (state == FLUSH2) begin
            ifid_flush = 1'b1;
        end else begin
            // MEM_WAIT exit behaves like RUN, but a frozen flush resumes afterwards
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                next        = FLUSH2;
            end else if (lu) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
            if (state == MEM_WAIT && flag) next = FLUSH2;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (!pc_we),
        .q    (stall_cycles)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, flush, freeze, saturation and reset behaviour.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_uses_rm, ex_memread, branch_taken, mem_busy;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [3:0] stall_cycles;
    int         checks = 0;
    int         failures = 0;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_uses_rm  (id_uses_rm),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .branch_taken(branch_taken),
        .mem_busy    (mem_busy),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // outputs packed as {pc_we, ifid_we, ifid_flush, idex_bubble}, sampled mid-cycle
    task automatic outs(input string tag, input logic [3:0] exp);
        #4;
        chk(tag, {4'b0, pc_we, ifid_we, ifid_flush, idex_bubble}, {4'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                         input logic br, input logic mb);
        reset = rst; ex_memread = mr; ex_rd = rd; id_rn = rn; id_rm = rm;
        id_uses_rm = urm; branch_taken = br; mem_busy = mb;
    endtask

    initial begin
        drive(1, 0, 0, 1, 2, 0, 0, 0);
        outs("reset_outs", 4'b1111);
        tick();
        chk("reset_cnt", 8'(stall_cycles), 8'd0);
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        outs("idle", 4'b1100);
        tick();
        drive(0, 1, 3, 3, 2, 0, 0, 0);
        outs("lu_rn", 4'b0001);
        tick();
        chk("lu_cnt", 8'(stall_cycles), 8'd1);
        drive(0, 0, 3, 3, 2, 0, 0, 0);
        outs("lu_clear", 4'b1100);
        tick();
        chk("lu_cnt_hold", 8'(stall_cycles), 8'd1);
        drive(0, 1, 5, 1, 5, 1, 0, 0);
        outs("lu_rm", 4'b0001);
        tick();
        drive(0, 1, 5, 1, 5, 0, 0, 0);
        outs("rm_unused", 4'b1100);
        tick();
        chk("rm_cnt", 8'(stall_cycles), 8'd2);
        drive(0, 1, 31, 31, 31, 1, 0, 0);
        outs("xzr", 4'b1100);
        tick();
        chk("xzr_cnt", 8'(stall_cycles), 8'd2);
        drive(0, 0, 0, 1, 2, 0, 1, 0);
        outs("br_c1", 4'b1111);
        tick();
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        outs("br_c2", 4'b1110);
        tick();
        outs("br_c3", 4'b1100);
        tick();
        drive(0, 1, 3, 3, 2, 0, 1, 0);
        outs("br_lu_c1", 4'b1111);
        tick();
        outs("br_lu_c2", 4'b1110);
        tick();
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        outs("br_lu_c3", 4'b1100);
        tick();
        chk("br_lu_cnt", 8'(stall_cycles), 8'd2);
        drive(1, 0, 0, 1, 2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 2, 0, 1, 0);
        outs("frz_br", 4'b1111);
        tick();
        drive(0, 0, 0, 1, 2, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            outs("frz_busy", 4'b0000);
            tick();
        end
        chk("frz_cnt", 8'(stall_cycles), 8'd3);
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        outs("frz_exit", 4'b1100);
        tick();
        outs("frz_flush", 4'b1110);
        tick();
        outs("frz_run", 4'b1100);
        tick();
        drive(0, 0, 0, 1, 2, 0, 0, 1);
        repeat (20) tick();
        chk("sat_cnt", 8'(stall_cycles), 8'd15);
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 2, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 2, 0, 1, 1);
        outs("busy_over_br", 4'b0000);
        tick();
        drive(1, 0, 0, 1, 2, 0, 0, 0);
        outs("rst_mw", 4'b1111);
        tick();
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        outs("post_rst1", 4'b1100);
        chk("post_rst_cnt", 8'(stall_cycles), 8'd0);
        tick();
        outs("post_rst2", 4'b1100);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the saturating stall-cycle counter.
REQ-002 Parameter ZERO_REG, default 31: register index hardwired to zero (XZR), never a hazard source.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rn  input  5  first source register of the instruction in ID.
REQ-006 id_rm  input  5  second source register of the instruction in ID.
REQ-007 id_uses_rm  input  1  ID instruction reads id_rm.
REQ-008 ex_rd  input  5  destination register of the instruction in EX.
REQ-009 ex_memread  input  1  EX instruction is a load.
REQ-010 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-011 mem_busy  input  1  data memory not ready; pipeline must freeze.
REQ-012 pc_we  output  1  PC register write enable.
REQ-013 ifid_we  output  1  IF/ID register write enable (0 = hold).
REQ-014 ifid_flush  output  1  IF/ID loads a NOP (32'h0) instead of the fetched word.
REQ-015 idex_bubble  output  1  ID/EX control fields forced to zero.
REQ-016 stall_cycles  output  CNT_W  saturating count of cycles with pc_we=0.

Function
REQ-017 FSM states: RUN, FLUSH2, MEM_WAIT; state register only, outputs combinational from state and inputs.
REQ-018 Load-use hazard (LU) = ex_memread & ex_rd!=ZERO_REG & (ex_rd==id_rn | (id_uses_rm & ex_rd==id_rm)).
REQ-019 Priority per cycle: reset > mem_busy > branch_taken > LU > normal.
REQ-020 mem_busy=1 in any state: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0; next state MEM_WAIT; a pending FLUSH2 is remembered in a 1-bit flag.
REQ-021 MEM_WAIT with mem_busy=0: outputs as RUN for this cycle; next state FLUSH2 if flag set (flag cleared), else RUN.
REQ-022 RUN, branch_taken=1: pc_we=1, ifid_flush=1, idex_bubble=1; next state FLUSH2.
REQ-023 FLUSH2: ifid_flush=1, pc_we=1, idex_bubble=0; next state RUN; branch_taken and LU ignored in FLUSH2.
REQ-024 RUN, LU=1, no branch: pc_we=0, ifid_we=0, idex_bubble=1; stays RUN (one bubble per load; next cycle ex_memread clears).
REQ-025 RUN, no event: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
REQ-026 ifid_we=1 whenever ifid_flush=1.
REQ-027 stall_cycles increments by 1 each cycle pc_we=0, holds at 2^CNT_W-1, never wraps.
REQ-028 Branch and LU in same cycle: branch wins, no pc_we=0 cycle.

Reset
REQ-029 reset=1 on posedge clk: state=RUN, flush flag=0, stall_cycles=0.
REQ-030 While reset=1: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1 (pipeline filled with NOPs).
REQ-031 Reset asserted mid-FLUSH2 or MEM_WAIT: pending flush discarded, RUN on next cycle.

Structure
REQ-032 State encoding and NOP constant (32'h0) in shared package pipe_pkg; ZERO_REG default there.
REQ-033 Single optional sub-module sat_counter (CNT_W-wide, enable, sync reset) for stall_cycles; FSM and LU logic inline.

Verification
REQ-034 Load X3 in EX (ex_memread=1, ex_rd=3), id_rn=3 -> one cycle pc_we=0, ifid_we=0, idex_bubble=1; stall_cycles 0->1.
REQ-035 ex_rd=31 load, id_rn=31 -> no stall; all enables 1, stall_cycles unchanged.
REQ-036 branch_taken pulse one cycle -> ifid_flush=1 for exactly two consecutive cycles, idex_bubble=1 first cycle only, pc_we=1 throughout.
REQ-037 branch_taken then mem_busy=1 for 3 cycles in FLUSH2 -> 3 frozen cycles, then ifid_flush=1 one cycle, then RUN; stall_cycles +3.
REQ-038 CNT_W=4, hold mem_busy 20 cycles -> stall_cycles saturates at 15.
REQ-039 reset asserted during MEM_WAIT -> next cycle RUN, stall_cycles=0, no residual flush.
